// File: rtl/seq_arith_pkg.sv
// Shared types and elaboration helpers for the sequential arithmetic blocks.
// Holds the subtractor FSM state type and the operand/digit width check.
package seq_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Operands must split into a whole number of non-empty digits.
    function automatic bit width_ok(input int width, input int digit);
        return (digit > 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple slice: s = a + b_n + cin, one full-adder cell per bit.
module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b_n,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = a[i] ^ b_n[i] ^ c;
            c    = (a[i] & b_n[i]) | (c & (a[i] ^ b_n[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/s_seq_sub16.sv
// Signed multi-cycle subtractor, diff = a - b (WIDTH+1 bits), DIGIT bits per cycle from the LSB.
// Define SEQ_SUB_BORROW_IN_EN to add a borrow-in port: diff = a - b - bin.
module s_seq_sub16
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_SUB_BORROW_IN_EN
    input  logic             bin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(NCYC - 1);

    generate
        if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
            $error("s_seq_sub16: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic             a_msb_q, a_msb_d;
    logic             bn_msb_q, bn_msb_d;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] diff_low_nx;
    logic             carry_init;

`ifdef SEQ_SUB_BORROW_IN_EN
    assign carry_init = ~bin;
`else
    assign carry_init = 1'b1;
`endif

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (a_sh_q[DIGIT-1:0]),
        .b_n  (b_sh_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (slice_sum),
        .cout (slice_cout)
    );

    // New sum digits enter at the top so the LSB digit lands at bit 0 after NCYC shifts.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign diff_low_nx = slice_sum;
        end else begin : g_multi_digit
            assign diff_low_nx = {slice_sum, diff_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        a_msb_d  = a_msb_q;
        bn_msb_d = bn_msb_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = BUSY;
                    a_sh_d   = a;
                    b_sh_d   = ~b;
                    carry_d  = carry_init;
                    cnt_d    = CNT_INIT;
                    a_msb_d  = a[WIDTH-1];
                    bn_msb_d = ~b[WIDTH-1];
                end
            end
            BUSY: begin
                a_sh_d              = a_sh_q >> DIGIT;
                b_sh_d              = b_sh_q >> DIGIT;
                carry_d             = slice_cout;
                diff_d[WIDTH-1:0]   = diff_low_nx;
                if (cnt_q == '0) begin
                    // Sign-extended top bit of a + ~b + cin, so the result never overflows.
                    diff_d[WIDTH] = a_msb_q ^ bn_msb_q ^ slice_cout;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            a_msb_q  <= 1'b0;
            bn_msb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            a_msb_q  <= a_msb_d;
            bn_msb_q <= bn_msb_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;

endmodule

// File: tb/tb_s_seq_sub16.sv
// Self-checking bench for s_seq_sub16: directed corner cases, backpressure, reset abort, random ops.
// Honours SEQ_SUB_BORROW_IN_EN when the bin port is built in.
module tb_s_seq_sub16;

    localparam int WIDTH = 16;
    localparam int DIGIT = 1;
    localparam int NCYC  = WIDTH / DIGIT;
`ifdef SEQ_SUB_BORROW_IN_EN
    localparam bit HAS_BIN = 1'b1;
`else
    localparam bit HAS_BIN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             binSig;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;

    int checkCount = 0;
    int errorCount = 0;

    s_seq_sub16 #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SEQ_SUB_BORROW_IN_EN
        .bin       (binSig),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain signed integer arithmetic, truncated to the exact WIDTH+1 result.
    function automatic logic [WIDTH:0] refDiff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic bi);
        longint r;
        r = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        return r[WIDTH:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal,
                                 input logic binVal);
        int waitCycles = 0;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("ready_wait", 64'(in_ready), 64'd1);
        a        = aVal;
        b        = bVal;
        binSig   = binVal;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
    endtask

    task automatic completeOp(input string tag, input logic [WIDTH:0] expected);
        int k = 0;
        while (!out_valid && k < NCYC + 5) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_latency"}, 64'(k), 64'(NCYC));
        checkOutput({tag, "_diff"}, 64'(diff), 64'(expected));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic runOp(input string tag, input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal,
                         input logic binVal, input logic [WIDTH:0] expected);
        applyStimulus(aVal, bVal, binVal);
        completeOp(tag, expected);
    endtask

    initial begin
        logic [WIDTH:0]   held;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rbin;
        int               k;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        binSig    = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_diff", 64'(diff), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("small", 16'h0005, 16'h0003, 1'b0, 17'h00002);
        runOp("min_minus_max", 16'h8000, 16'h7FFF, 1'b0, 17'h10001);
        runOp("max_minus_min", 16'h7FFF, 16'h8000, 1'b0, 17'h0FFFF);
        runOp("zero_minus_min", 16'h0000, 16'h8000, 1'b0, 17'h08000);
        runOp("equal_neg", 16'hFFFF, 16'hFFFF, 1'b0, 17'h00000);
        runOp("neg_result", 16'h0003, 16'h0005, 1'b0, 17'h1FFFE);
`ifdef SEQ_SUB_BORROW_IN_EN
        runOp("borrow_zero", 16'h0000, 16'h0000, 1'b1, 17'h1FFFF);
        runOp("borrow_min", 16'h8000, 16'h7FFF, 1'b1, 17'h10000);
`endif

        // Backpressure: result must hold and no new operands may be taken.
        applyStimulus(16'h1234, 16'h0F0F, 1'b0);
        k = 0;
        while (!out_valid && k < NCYC + 5) begin
            @(negedge clk);
            k++;
        end
        checkOutput("bp_latency", 64'(k), 64'(NCYC));
        held     = diff;
        checkOutput("bp_diff", 64'(held), 64'(17'h00325));
        in_valid = 1'b1;
        a        = 16'h7777;
        b        = 16'h1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_hold", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_diff_hold", 64'(diff), 64'(held));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_no_accept_on_handshake", 64'(in_ready), 64'd1);
        checkOutput("bp_valid_drop", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        runOp("after_bp", 16'h7777, 16'h1111, 1'b0, 17'h06666);

        // Reset in the middle of an operation discards it.
        applyStimulus(16'h4000, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_diff", 64'(diff), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_idle", 64'(in_ready), 64'd1);
        runOp("after_abort", 16'hFFFE, 16'h0002, 1'b0, 17'h1FFFC);

        for (int n = 0; n < 400; n++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rbin = HAS_BIN ? 1'($urandom) : 1'b0;
            if (n % 10 == 0) ra = {1'b1, {(WIDTH-1){1'b0}}};
            if (n % 10 == 5) rb = {1'b0, {(WIDTH-1){1'b1}}};
            runOp("random", ra, rb, rbin, refDiff(ra, rb, rbin));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
